ahb_lite_slave_regbank: RTL and testbench

- Parametrised AHB-Lite slave that succeeds the single-width slave interface.
- Implements a bank of NUM_REGS memory-mapped registers, each DATA_WIDTH bits wide, inside a 4 KB window.
- Supports byte, halfword and word lanes, a programmable number of wait states, and the full two-cycle AHB ERROR response.
- Sits behind the bus decoder; HSELx comes from the decoder, and HREADY is the muxed bus HREADY.

---
 rtl/ahb_lite_slave_regbank_if.sv | 29 ++
 rtl/ahb_lite_slave_regbank.sv | 156 +++++++++++++++
 tb/tb_ahb_lite_slave_regbank.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_slave_regbank_if.sv
// AHB-Lite bus bundle between one master/decoder side and the register-bank slave.
// HREADY is the muxed bus ready, so it is driven from the master/system side.
interface ahb_lite_slave_regbank_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  HSELx;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [1:0]            HTRANS;
  logic                  HREADY;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADYOUT;
  logic                  HRESP;
  logic [DATA_WIDTH-1:0] HRDATA;

  modport master (
    output HSELx, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY, HWDATA,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSELx, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY, HWDATA,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_lite_slave_regbank.sv
// AHB-Lite slave exposing NUM_REGS registers of DATA_WIDTH bits in a 4 KB window.
// Byte/halfword/word lanes, WAIT_STATES wait cycles per OKAY transfer, two-cycle ERROR.
// Optional macro AHB_SLAVE_ALIGN_CHECK_EN: misaligned transfers take the ERROR path
// instead of being aligned down to the HSIZE boundary.
module ahb_lite_slave_regbank #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic                     HCLK,
  input logic                     HRESETn,
  ahb_lite_slave_regbank_if.slave bus
);

  localparam int unsigned ByteW    = DATA_WIDTH / 8;
  localparam int unsigned LaneBits = $clog2(ByteW);
  localparam int unsigned IdxW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned KeepW    = LaneBits + IdxW;
  localparam logic [2:0]  MaxSize  = 3'(LaneBits);
  localparam logic [11:0] NumRegs  = 12'(NUM_REGS);
  localparam logic [2:0]  WaitLoad = 3'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

  state_e                state_q;
  logic [2:0]            cnt_q;
  logic                  ready_q;
  logic                  resp_q;
  logic [KeepW-1:0]      addr_q;
  logic                  write_q;
  logic [2:0]            size_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic             valid;
  logic             accepting;
  logic [11:0]      word_idx;
  logic             misalign;
  logic             req_err;
  state_e           accept_state;
  logic             accept_ready;
  logic             accept_resp;
  logic [IdxW-1:0]  reg_idx;
  logic [ByteW-1:0] lane_en;
  logic             unused_bits;

  assign valid     = bus.HSELx & bus.HREADY & bus.HTRANS[1];
  // Only the completing/idle states may take a new address phase.
  assign accepting = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);
  assign word_idx  = bus.HADDR[11:0] >> LaneBits;

`ifdef AHB_SLAVE_ALIGN_CHECK_EN
  assign misalign = |(bus.HADDR[11:0] & ((12'd1 << bus.HSIZE) - 12'd1));
`else
  assign misalign = 1'b0;
`endif

  assign req_err = (bus.HSIZE > MaxSize) || (word_idx >= NumRegs) || misalign;

  // Next state and registered outputs implied by the address phase on the bus now.
  always_comb begin
    accept_state = StIdle;
    accept_ready = 1'b1;
    accept_resp  = 1'b0;
    if (valid) begin
      if (req_err) begin
        accept_state = StErr1;
        accept_ready = 1'b0;
        accept_resp  = 1'b1;
      end else if (WAIT_STATES > 0) begin
        accept_state = StWait;
        accept_ready = 1'b0;
      end else begin
        accept_state = StData;
      end
    end
  end

  // Transfer FSM with registered HREADYOUT/HRESP.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      resp_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StWait: begin
          if (cnt_q == 3'd0) begin
            state_q <= StData;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        StErr1: begin
          state_q <= StErr2;
          ready_q <= 1'b1;
          resp_q  <= 1'b1;
        end
        default: begin
          state_q <= accept_state;
          ready_q <= accept_ready;
          resp_q  <= accept_resp;
          cnt_q   <= WaitLoad;
        end
      endcase
    end
  end

  // Address-phase capture; only the bits that select register and lanes are kept.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else if (valid && accepting) begin
      addr_q  <= bus.HADDR[KeepW-1:0];
      write_q <= bus.HWRITE;
      size_q  <= bus.HSIZE;
    end
  end

  assign reg_idx = addr_q[KeepW-1:LaneBits];

  // A byte lane is enabled when it lies in the same size-aligned block as the address.
  always_comb begin
    lane_en = '0;
    for (int unsigned i = 0; i < ByteW; i++) begin
      lane_en[i] = ((i >> size_q) == (32'(addr_q[LaneBits-1:0]) >> size_q));
    end
  end

  // Register bank: write commits at the edge that ends the DATA cycle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if ((state_q == StData) && write_q) begin
      for (int unsigned b = 0; b < ByteW; b++) begin
        if (lane_en[b]) begin
          regs_q[reg_idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
        end
      end
    end
  end

  assign bus.HREADYOUT = ready_q;
  assign bus.HRESP     = resp_q;
  assign bus.HRDATA    = ((state_q == StData) && !write_q) ? regs_q[reg_idx] : '0;

  // HBURST/HPROT are accepted but carry no meaning for a register bank.
  assign unused_bits = ^{bus.HBURST, bus.HPROT, bus.HTRANS[0], bus.HADDR[ADDR_WIDTH-1:KeepW]};

endmodule

// File: tb/tb_ahb_lite_slave_regbank.sv
// Bench for ahb_lite_slave_regbank: one zero-wait and one two-wait instance, directed
// cases followed by random pipelined transfers checked against a byte-level memory model.
module tb_ahb_lite_slave_regbank;

  localparam int unsigned Ws0 = 0;
  localparam int unsigned Ws1 = 2;

  typedef struct {
    bit        wr;
    bit [11:0] a;
    bit [2:0]  s;
    bit [1:0]  tr;
    bit [31:0] wd;
  } xfer_t;

  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  logic        dsel;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        o_rdy;
  logic        o_resp;
  logic [31:0] o_rdata;

  int n_vec = 0;
  int n_bad = 0;

  bit [31:0] mem [2][16];
  xfer_t     q [$];

  ahb_lite_slave_regbank_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) if0 ();
  ahb_lite_slave_regbank_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) if1 ();

  assign if0.HSELx  = hsel & ~dsel;
  assign if1.HSELx  = hsel & dsel;
  assign if0.HADDR  = haddr;
  assign if1.HADDR  = haddr;
  assign if0.HWRITE = hwrite;
  assign if1.HWRITE = hwrite;
  assign if0.HSIZE  = hsize;
  assign if1.HSIZE  = hsize;
  assign if0.HBURST = 3'b000;
  assign if1.HBURST = 3'b000;
  assign if0.HPROT  = 4'b0011;
  assign if1.HPROT  = 4'b0011;
  assign if0.HTRANS = htrans;
  assign if1.HTRANS = htrans;
  assign if0.HWDATA = hwdata;
  assign if1.HWDATA = hwdata;
  assign if0.HREADY = if0.HREADYOUT;
  assign if1.HREADY = if1.HREADYOUT;

  assign o_rdy   = dsel ? if1.HREADYOUT : if0.HREADYOUT;
  assign o_resp  = dsel ? if1.HRESP     : if0.HRESP;
  assign o_rdata = dsel ? if1.HRDATA    : if0.HRDATA;

  ahb_lite_slave_regbank #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(Ws0)
  ) u_dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(if0)
  );

  ahb_lite_slave_regbank #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(Ws1)
  ) u_dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(if1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_err(input bit [11:0] a, input bit [2:0] s);
    int unsigned ai;
    ai = 32'(a);
    if (s > 3'd2) return 1'b1;
    if (ai / 4 >= 16) return 1'b1;
`ifdef AHB_SLAVE_ALIGN_CHECK_EN
    if (ai % (32'd1 << s) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Bytes from the size-aligned base up to base+size are replaced.
  function automatic void model_write(input int d, input bit [11:0] a, input bit [2:0] s,
                                      input bit [31:0] wd);
    int unsigned nb;
    int unsigned base;
    nb   = 32'd1 << s;
    base = (32'(a) / nb) * nb;
    for (int unsigned b = base; b < base + nb; b++) begin
      mem[d][b / 4][(b % 4) * 8 +: 8] = wd[(b % 4) * 8 +: 8];
    end
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 16; r++) mem[d][r] = 32'h0;
    end
  endfunction

  task automatic drive_addr(input xfer_t t);
    hsel   = 1'b1;
    haddr  = {20'h0, t.a};
    hwrite = t.wr;
    hsize  = t.s;
    htrans = t.tr;
  endtask

  task automatic drive_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  task automatic add(input bit wr, input bit [11:0] a, input bit [2:0] s, input bit [31:0] wd);
    xfer_t t;
    t.wr = wr;
    t.a  = a;
    t.s  = s;
    t.tr = 2'b10;
    t.wd = wd;
    q.push_back(t);
  endtask

  // Issue the queued transfers back-to-back to the selected instance.
  task automatic run_batch();
    xfer_t       t;
    bit          e;
    bit [31:0]   er;
    int          w;
    int unsigned ws;
    ws = dsel ? Ws1 : Ws0;
    @(negedge HCLK);
    drive_addr(q[0]);
    for (int k = 0; k < q.size(); k++) begin
      t  = q[k];
      e  = exp_err(t.a, t.s);
      er = (!e && !t.wr) ? mem[dsel][t.a / 4] : 32'h0;
      @(negedge HCLK);
      hwdata = t.wd;
      if (k + 1 < q.size()) drive_addr(q[k + 1]);
      else drive_idle();
      w = 0;
      while (!o_rdy && w < 16) begin
        check("stall_resp", o_resp, e);
        check("stall_rdata", o_rdata, 0);
        @(negedge HCLK);
        w++;
      end
      if (w >= 16) begin
        n_vec++;
        n_bad++;
        $error("FAIL hreadyout_timeout observed=low expected=high within 16 cycles");
      end
      check("wait_cycles", w, e ? 1 : ws);
      check("resp", o_resp, e);
      check("rdata", o_rdata, er);
      if (!e && t.wr) model_write(int'(dsel), t.a, t.s, t.wd);
    end
    q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int    len;
    xfer_t t;
    HRESETn = 1'b0;
    dsel    = 1'b0;
    hwdata  = 32'h0;
    haddr   = 32'h0;
    hsize   = 3'd2;
    drive_idle();
    model_reset();
    repeat (3) @(negedge HCLK);
    check("rst_rdy0", if0.HREADYOUT, 1);
    check("rst_resp0", if0.HRESP, 0);
    check("rst_rdata0", if0.HRDATA, 0);
    check("rst_rdy1", if1.HREADYOUT, 1);
    check("rst_resp1", if1.HRESP, 0);
    HRESETn = 1'b1;

    // Write then read back-to-back on the zero-wait instance.
    add(1'b1, 12'h004, 3'd2, 32'hDEADBEEF);
    add(1'b0, 12'h004, 3'd2, 32'h0);
    run_batch();

    // Byte lane update inside a word.
    add(1'b1, 12'h008, 3'd2, 32'h11223344);
    add(1'b1, 12'h009, 3'd0, 32'h0000AA00);
    add(1'b0, 12'h008, 3'd2, 32'h0);
    run_batch();

    // Oversize and out-of-window transfers, then an OKAY read.
    add(1'b1, 12'h004, 3'd3, 32'h55555555);
    add(1'b1, 12'h040, 3'd2, 32'h66666666);
    add(1'b0, 12'h004, 3'd2, 32'h0);
    run_batch();

    // Halfword at an odd address.
    add(1'b1, 12'h000, 3'd2, 32'hA5A5A5A5);
    add(1'b1, 12'h001, 3'd1, 32'h0000BEEF);
    add(1'b0, 12'h000, 3'd2, 32'h0);
    run_batch();

    // IDLE and BUSY with select and write asserted must do nothing.
    @(negedge HCLK);
    hsel   = 1'b1;
    htrans = 2'b00;
    hwrite = 1'b1;
    haddr  = 32'h4;
    hsize  = 3'd2;
    hwdata = 32'hFFFFFFFF;
    @(negedge HCLK);
    check("idle_rdy", o_rdy, 1);
    check("idle_resp", o_resp, 0);
    htrans = 2'b01;
    @(negedge HCLK);
    check("busy_rdy", o_rdy, 1);
    check("busy_resp", o_resp, 0);
    drive_idle();
    @(negedge HCLK);
    check("busy_after_rdy", o_rdy, 1);
    add(1'b0, 12'h004, 3'd2, 32'h0);
    run_batch();

    // Two-wait instance.
    dsel = 1'b1;
    add(1'b0, 12'h000, 3'd2, 32'h0);
    add(1'b1, 12'h010, 3'd2, 32'hCAFEF00D);
    add(1'b0, 12'h010, 3'd2, 32'h0);
    add(1'b1, 12'h03C, 3'd1, 32'h12345678);
    add(1'b0, 12'h03C, 3'd2, 32'h0);
    run_batch();

    // Reset asserted during a WAIT cycle abandons the write.
    @(negedge HCLK);
    t.wr = 1'b1;
    t.a  = 12'h00C;
    t.s  = 3'd2;
    t.tr = 2'b10;
    t.wd = 32'h12345678;
    drive_addr(t);
    @(negedge HCLK);
    hwdata = t.wd;
    drive_idle();
    check("wait_before_rst", o_rdy, 0);
    HRESETn = 1'b0;
    #1;
    check("rst_mid_rdy", o_rdy, 1);
    check("rst_mid_resp", o_resp, 0);
    check("rst_mid_rdata", o_rdata, 0);
    model_reset();
    @(negedge HCLK);
    HRESETn = 1'b1;
    add(1'b0, 12'h00C, 3'd2, 32'h0);
    run_batch();

    // Random pipelined bursts on both instances.
    for (int d = 0; d < 2; d++) begin
      dsel = d[0];
      for (int r = 0; r < 12; r++) begin
        len = $urandom_range(1, 6);
        for (int k = 0; k < len; k++) begin
          t.wr = 1'($urandom_range(0, 1));
          t.a  = 12'($urandom_range(0, 'h4F));
          t.s  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
          t.tr = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b11;
          t.wd = $urandom;
          q.push_back(t);
        end
        run_batch();
      end
      for (int r = 0; r < 16; r++) add(1'b0, 12'(r * 4), 3'd2, 32'h0);
      run_batch();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
